puf_chal_seq: RTL and testbench

Challenge sequencer that sits directly downstream of the 128-bit Galois challenge LFSR in the PUF lab datapath. It steps the LFSR a programmable number of times per challenge and latches the 128-bit state as a challenge. It presents each challenge to the PUF array over a valid/ready handshake and repeats for a requested challenge count. It signals completion or LFSR lock-up to the controller.

---
 rtl/puf_chal_seq.sv | 163 ++++++++++++++++
 tb/tb_puf_chal_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_chal_seq.sv
// Challenge sequencer: steps the challenge LFSR STRIDE times per challenge and presents it.
// Optional LFSR lock-up detection is enabled by defining PUF_CHAL_SEQ_ZERO_CHK_EN.
module puf_chal_seq #(
    parameter int STRIDE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_chal,
    input  logic [127:0]     lfsr_stage,
    output logic             lfsr_en,
    output logic [127:0]     chal,
    output logic             chal_valid,
    input  logic             chal_ready,
    output logic [CNT_W-1:0] chal_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_LOAD,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [SW-1:0] STEP_INIT = SW'(STRIDE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [SW-1:0]    step_q, step_d;
    logic [127:0]     chal_q, chal_d;
    logic             valid_q, valid_d;

`ifdef PUF_CHAL_SEQ_ZERO_CHK_EN
    logic err_q, err_d;
    logic lock_up;

    assign lock_up = (lfsr_stage == '0);
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        step_d  = step_q;
        chal_d  = chal_q;
        valid_d = valid_q;
`ifdef PUF_CHAL_SEQ_ZERO_CHK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef PUF_CHAL_SEQ_ZERO_CHK_EN
                    err_d = 1'b0;
`endif
                    if (num_chal != '0) begin
                        rem_d   = num_chal;
                        idx_d   = '0;
                        step_d  = STEP_INIT;
                        state_d = S_STEP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_STEP: begin
                if (step_q == '0) begin
                    state_d = S_LOAD;
                end else begin
                    step_d = step_q - SW'(1);
                end
            end
            S_LOAD: begin
`ifdef PUF_CHAL_SEQ_ZERO_CHK_EN
                if (lock_up) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    chal_d  = lfsr_stage;
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end
`else
                chal_d  = lfsr_stage;
                valid_d = 1'b1;
                state_d = S_PRESENT;
`endif
            end
            S_PRESENT: begin
                if (valid_q && chal_ready) begin
                    valid_d = 1'b0;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        step_d  = STEP_INIT;
                        state_d = S_STEP;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // abort overrides every transition outside IDLE
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            step_q  <= '0;
            chal_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            chal_q  <= chal_d;
            valid_q <= valid_d;
        end
    end

`ifdef PUF_CHAL_SEQ_ZERO_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign lfsr_en    = (state_q == S_STEP);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign chal       = chal_q;
    assign chal_valid = valid_q;
    assign chal_idx   = idx_q;

endmodule

// File: tb/tb_puf_chal_seq.sv
// Scoreboard bench for puf_chal_seq: a bench-side Galois LFSR feeds the DUT,
// expected challenges are queued at start and checked by an independent monitor.
module tb_puf_chal_seq;

    localparam int S  = 4;
    localparam int CW = 16;
    localparam logic [127:0] SEED = 128'h0123_4567_89ab_cdef_f00d_cafe_1357_9bdf;
    localparam logic [127:0] TAPS = (128'h1 << 127) | (128'h1 << 28)
                                  | (128'h1 << 26) | (128'h1 << 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic chal_ready = 1'b0;
    logic zero_force = 1'b0;
    logic [CW-1:0] num_chal = '0;
    logic [127:0] lfsr_q = SEED;
    logic [127:0] lfsr_stage;
    logic [127:0] chal;
    logic lfsr_en, chal_valid, busy, done, err;
    logic [CW-1:0] chal_idx;

    typedef struct packed {
        logic [127:0] c;
        logic [CW-1:0] i;
    } exp_t;

    exp_t q[$];
    logic [127:0] base = SEED;
    int pass_cnt = 0;
    int chk_cnt = 0;
    int en_cnt = 0;
    int done_cnt = 0;

    puf_chal_seq #(.STRIDE(S), .CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .num_chal(num_chal),
        .lfsr_stage(lfsr_stage),
        .lfsr_en(lfsr_en),
        .chal(chal),
        .chal_valid(chal_valid),
        .chal_ready(chal_ready),
        .chal_idx(chal_idx),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] step1(input logic [127:0] s);
        logic [127:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ TAPS;
        return r;
    endfunction

    function automatic logic [127:0] adv(input logic [127:0] s, input int n);
        logic [127:0] r;
        r = s;
        for (int k = 0; k < n; k++) r = step1(r);
        return r;
    endfunction

    assign lfsr_stage = zero_force ? '0 : lfsr_q;

    always @(posedge clk) begin
        if (lfsr_en) begin
            lfsr_q <= step1(lfsr_q);
            en_cnt <= en_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input int n);
        for (int k = 0; k < n; k++)
            q.push_back('{c: adv(base, S * (k + 1)), i: CW'(k)});
        base = adv(base, S * n);
        start = 1'b1;
        num_chal = CW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic cnt_to_valid(output int c);
        c = 1;
        while (!chal_valid && c < 50) begin
            tick();
            c++;
        end
    endtask

    task automatic wait_done(input int bound, input bit rnd);
        int c;
        c = 0;
        while (c < bound) begin
            if (done) break;
            if (rnd) begin
                chal_ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 7) == 0);
                num_chal = CW'($urandom_range(0, 9));
            end
            tick();
            c++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        tick();
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    // monitor: scoreboard pops, hold-stable and lfsr_en legality
    initial begin
        logic pv, phs, hs;
        logic [127:0] pc;
        exp_t e;
        pv = 0;
        phs = 0;
        pc = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pv = 0;
                phs = 0;
            end else begin
                if (lfsr_en) chk("en_legal", chal_valid | done, 0);
                if (pv && !phs) begin
                    chk("hold_valid", chal_valid, 1);
                    chk("hold_chal", chal, pc);
                end
                hs = chal_valid && chal_ready;
                if (hs) begin
                    chk_cnt++;
                    if (q.size() == 0) begin
                        $display("FAIL sb_empty: got chal %h expected none", chal);
                    end else begin
                        pass_cnt++;
                        e = q.pop_front();
                        chk("sb_chal", chal, e.c);
                        chk("sb_idx", chal_idx, e.i);
                    end
                end
                pv = chal_valid;
                phs = hs;
                pc = chal;
            end
        end
    end

    initial begin
        int c, e0, d0;
        repeat (3) tick();
        chk("rst_en", lfsr_en, 0);
        chk("rst_chal", chal, 0);
        chk("rst_valid", chal_valid, 0);
        chk("rst_idx", chal_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // timing with a 5-cycle stall after the first valid
        e0 = en_cnt;
        chal_ready = 1'b0;
        issue(2);
        chk("first_en", lfsr_en, 1);
        cnt_to_valid(c);
        chk("first_valid_lat", c, S + 2);
        repeat (5) tick();
        chal_ready = 1'b1;
        tick();
        cnt_to_valid(c);
        chk("next_valid_lat", c, S + 2);
        tick();
        chk("done_after_hs", done, 1);
        tick();
        chk("busy_low", busy, 0);
        chk("en_total_2", en_cnt - e0, 2 * S);
        chk("lfsr_pos_a", lfsr_q, base);

        // zero-length run
        e0 = en_cnt;
        d0 = done_cnt;
        issue(0);
        chk("z_done", done, 1);
        chk("z_busy", busy, 1);
        tick();
        chk("z_busy_low", busy, 0);
        chk("z_en_none", en_cnt - e0, 0);
        chk("z_done_cnt", done_cnt - d0, 1);

        // abort in the second STEP cycle
        e0 = en_cnt;
        d0 = done_cnt;
        issue(3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_en", lfsr_en, 0);
        chk("ab_busy", busy, 0);
        repeat (3) tick();
        chk("ab_no_done", done_cnt - d0, 0);
        chk("ab_steps", en_cnt - e0, 2);
        q.delete();
        base = lfsr_q;

        // all-zero stage during LOAD
`ifndef PUF_CHAL_SEQ_ZERO_CHK_EN
        q.push_back('{c: '0, i: '0});
`endif
        base = adv(base, S);
        chal_ready = 1'b0;
        start = 1'b1;
        num_chal = CW'(1);
        tick();
        start = 1'b0;
        repeat (S - 1) tick();
        zero_force = 1'b1;
        tick();
        chk("zf_load_en", lfsr_en, 0);
        tick();
        zero_force = 1'b0;
`ifdef PUF_CHAL_SEQ_ZERO_CHK_EN
        chk("zf_err", err, 1);
        chk("zf_done", done, 1);
        chk("zf_valid", chal_valid, 0);
        tick();
        chk("zf_err_sticky", err, 1);
        issue(1);
        chk("zf_err_clr", err, 0);
        chal_ready = 1'b1;
        wait_done(100, 0);
`else
        chk("zf_valid", chal_valid, 1);
        chk("zf_chal", chal, 0);
        chk("zf_err", err, 0);
        chal_ready = 1'b1;
        wait_done(20, 0);
`endif
        chk("lfsr_pos_z", lfsr_q, base);

        // randomized runs with random backpressure and stray starts
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 5);
            e0 = en_cnt;
            chal_ready = 1'b1;
            issue(n);
            wait_done(n * (S + 2) * 10 + 20, 1);
            chk("rnd_steps", en_cnt - e0, n * S);
            chk("rnd_lfsr_pos", lfsr_q, base);
            chk("rnd_sb_drained", q.size(), 0);
        end

        // reset while presenting
        chal_ready = 1'b0;
        issue(2);
        cnt_to_valid(c);
        chk("pr_valid", chal_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", chal_valid, 0);
        chk("ar_chal", chal, 0);
        chk("ar_busy", busy, 0);
        chk("ar_en", lfsr_en, 0);
        chk("ar_idx", chal_idx, 0);
        chk("ar_done", done, 0);
        chk("ar_err", err, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        base = lfsr_q;
        chal_ready = 1'b1;
        issue(1);
        chk("ar_restart", busy, 1);
        wait_done(40, 0);
        chk("lfsr_pos_r", lfsr_q, base);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
